// File: rtl/qspi_boot_pkg.sv
// Shared types and QSPI master register map for the boot copier.
package qspi_boot_pkg;

    localparam logic [31:0] QSPI_CTRL_OFF = 32'h0000_0000;
    localparam logic [31:0] QSPI_ADDR_OFF = 32'h0000_0004;
    localparam logic [31:0] QSPI_DATA_OFF = 32'h0000_0008;
    localparam logic [31:0] QSPI_STAT_OFF = 32'h0000_0028;
    localparam logic [31:0] QSPI_CMD_READ = 32'h0000_0003;

    localparam int unsigned HOLD_CYCLES = 4;
    localparam int unsigned POLL_LIMIT  = 1024;
    localparam int unsigned POLL_CNT_W  = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_ADDR,
        ST_WR_CTRL,
        ST_HOLD,
        ST_POLL,
        ST_RD_DATA,
        ST_MEM_WR,
        ST_FIN
    } boot_state_e;

    typedef enum logic [2:0] {
        AX_IDLE,
        AX_WR,
        AX_WB,
        AX_RA,
        AX_RD
    } axil_state_e;

    // One register access towards the QSPI master
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } axil_cmd_t;

endpackage

// File: rtl/axil_single_master.sv
// Issues a single AXI4-Lite read or write per req pulse; ack pulses with rdata valid.
module axil_single_master
    import qspi_boot_pkg::*;
(
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        req,
    input  axil_cmd_t   cmd,
    output logic        ack,
    output logic [31:0] rdata,
    output logic [31:0] awaddr,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic        wvalid,
    input  logic        wready,
    input  logic        bvalid,
    output logic        bready,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata_in,
    input  logic        rvalid,
    output logic        rready
);

    axil_state_e state;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state   <= AX_IDLE;
            ack     <= 1'b0;
            rdata   <= '0;
            awaddr  <= '0;
            awvalid <= 1'b0;
            wdata   <= '0;
            wvalid  <= 1'b0;
            bready  <= 1'b0;
            araddr  <= '0;
            arvalid <= 1'b0;
            rready  <= 1'b0;
        end else begin
            ack <= 1'b0;
            case (state)
                AX_IDLE: begin
                    if (req) begin
                        if (cmd.we) begin
                            awaddr  <= cmd.addr;
                            wdata   <= cmd.data;
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            state   <= AX_WR;
                        end else begin
                            araddr  <= cmd.addr;
                            arvalid <= 1'b1;
                            state   <= AX_RA;
                        end
                    end
                end
                AX_WR: begin
                    // address and data channels complete independently
                    if (awready) awvalid <= 1'b0;
                    if (wready)  wvalid  <= 1'b0;
                    if ((!awvalid || awready) && (!wvalid || wready)) begin
                        bready <= 1'b1;
                        state  <= AX_WB;
                    end
                end
                AX_WB: begin
                    if (bvalid) begin
                        bready <= 1'b0;
                        ack    <= 1'b1;
                        state  <= AX_IDLE;
                    end
                end
                AX_RA: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= AX_RD;
                    end
                end
                AX_RD: begin
                    if (rvalid) begin
                        rready <= 1'b0;
                        rdata  <= rdata_in;
                        ack    <= 1'b1;
                        state  <= AX_IDLE;
                    end
                end
                default: state <= AX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/qspi_boot_copier.sv
// Copies BOOT_WORDS words from QSPI flash into memory, then releases core reset.
// Optional QSPI_BOOT_TIMEOUT_EN bounds status polling and reports failure on err.
module qspi_boot_copier
    import qspi_boot_pkg::*;
#(
    parameter int unsigned BOOT_WORDS = 1024,
    parameter logic [31:0] FLASH_BASE = 32'h0010_0000,
    parameter logic [31:0] MEM_BASE   = 32'h0000_0000
) (
    input  logic        aclk,
    input  logic        aresetn,
    output logic [31:0] m_axi_awaddr,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    output logic [31:0] m_axi_araddr,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [31:0] m_axi_rdata,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        core_rst_n
);

    boot_state_e state;
    logic [31:0] idx;
    logic        pend;
    logic [1:0]  hold_cnt;
    logic        ax_req;
    axil_cmd_t   ax_cmd;
    logic        ax_ack;
    logic [31:0] ax_rdata;
    logic [31:0] flash_addr_c;
    logic [31:0] mem_addr_c;

    assign flash_addr_c = FLASH_BASE + {idx[29:0], 2'b00};
    assign mem_addr_c   = MEM_BASE   + {idx[29:0], 2'b00};

`ifdef QSPI_BOOT_TIMEOUT_EN
    logic [POLL_CNT_W-1:0] poll_cnt;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= ST_IDLE;
            idx        <= '0;
            pend       <= 1'b0;
            hold_cnt   <= '0;
            ax_req     <= 1'b0;
            ax_cmd     <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            core_rst_n <= 1'b0;
`ifdef QSPI_BOOT_TIMEOUT_EN
            poll_cnt   <= '0;
            err        <= 1'b0;
`endif
        end else begin
            ax_req <= 1'b0;
            done   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        busy  <= 1'b1;
                        idx   <= '0;
                        state <= (BOOT_WORDS == 0) ? ST_FIN : ST_WR_ADDR;
                    end
                end
                ST_WR_ADDR: begin
                    if (!pend) begin
                        ax_req <= 1'b1;
                        pend   <= 1'b1;
                        ax_cmd <= '{we: 1'b1, addr: QSPI_ADDR_OFF, data: flash_addr_c};
                    end else if (ax_ack) begin
                        pend  <= 1'b0;
                        state <= ST_WR_CTRL;
                    end
                end
                ST_WR_CTRL: begin
                    if (!pend) begin
                        ax_req <= 1'b1;
                        pend   <= 1'b1;
                        ax_cmd <= '{we: 1'b1, addr: QSPI_CTRL_OFF, data: QSPI_CMD_READ};
                    end else if (ax_ack) begin
                        pend     <= 1'b0;
                        hold_cnt <= '0;
                        state    <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // give the QSPI master time to raise its busy flag
                    if (hold_cnt == 2'(HOLD_CYCLES - 1)) begin
                        state <= ST_POLL;
`ifdef QSPI_BOOT_TIMEOUT_EN
                        poll_cnt <= '0;
`endif
                    end else begin
                        hold_cnt <= hold_cnt + 2'd1;
                    end
                end
                ST_POLL: begin
                    if (!pend) begin
                        ax_req <= 1'b1;
                        pend   <= 1'b1;
                        ax_cmd <= '{we: 1'b0, addr: QSPI_STAT_OFF, data: 32'h0};
                    end else if (ax_ack) begin
                        pend <= 1'b0;
                        if (!ax_rdata[0]) begin
                            state <= ST_RD_DATA;
                        end
`ifdef QSPI_BOOT_TIMEOUT_EN
                        else if (poll_cnt == POLL_CNT_W'(POLL_LIMIT - 1)) begin
                            err   <= 1'b1;
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end else begin
                            poll_cnt <= poll_cnt + POLL_CNT_W'(1);
                        end
`endif
                    end
                end
                ST_RD_DATA: begin
                    if (!pend) begin
                        ax_req <= 1'b1;
                        pend   <= 1'b1;
                        ax_cmd <= '{we: 1'b0, addr: QSPI_DATA_OFF, data: 32'h0};
                    end else if (ax_ack) begin
                        pend      <= 1'b0;
                        mem_req   <= 1'b1;
                        mem_addr  <= mem_addr_c;
                        mem_wdata <= ax_rdata;
                        state     <= ST_MEM_WR;
                    end
                end
                ST_MEM_WR: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        idx     <= idx + 32'd1;
                        state   <= (idx + 32'd1 == 32'(BOOT_WORDS)) ? ST_FIN : ST_WR_ADDR;
                    end
                end
                ST_FIN: begin
                    done       <= 1'b1;
                    core_rst_n <= 1'b1;
                    busy       <= 1'b0;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    axil_single_master u_axil (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .req      (ax_req),
        .cmd      (ax_cmd),
        .ack      (ax_ack),
        .rdata    (ax_rdata),
        .awaddr   (m_axi_awaddr),
        .awvalid  (m_axi_awvalid),
        .awready  (m_axi_awready),
        .wdata    (m_axi_wdata),
        .wvalid   (m_axi_wvalid),
        .wready   (m_axi_wready),
        .bvalid   (m_axi_bvalid),
        .bready   (m_axi_bready),
        .araddr   (m_axi_araddr),
        .arvalid  (m_axi_arvalid),
        .arready  (m_axi_arready),
        .rdata_in (m_axi_rdata),
        .rvalid   (m_axi_rvalid),
        .rready   (m_axi_rready)
    );

endmodule

// File: tb/tb_qspi_boot_copier.sv
// Bench for qspi_boot_copier: behavioural QSPI master/memory slave plus table-driven boots.
module tb_qspi_boot_copier;

    localparam int unsigned BW = 2;
    localparam logic [31:0] FB = 32'h0010_0000;
    localparam logic [31:0] MB = 32'h0000_0000;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
    logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic        m_axi_rvalid, m_axi_rready;
    logic        mem_req, mem_gnt;
    logic [31:0] mem_addr, mem_wdata;
    logic        start, busy, done, err, core_rst_n;

    // zero-word instance
    logic        zero1 = 1'b0;
    logic [31:0] zero32 = 32'h0;
    logic        start0, busy0, done0, err0, core0;
    logic [31:0] z_awaddr, z_wdata, z_araddr, z_maddr, z_mwdata;
    logic        z_awvalid, z_wvalid, z_bready, z_arvalid, z_rready, z_mreq;

    always #5 aclk = ~aclk;

    qspi_boot_copier #(.BOOT_WORDS(BW), .FLASH_BASE(FB), .MEM_BASE(MB)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
        .start(start), .busy(busy), .done(done), .err(err), .core_rst_n(core_rst_n)
    );

    qspi_boot_copier #(.BOOT_WORDS(0)) dut0 (
        .aclk(aclk), .aresetn(aresetn),
        .m_axi_awaddr(z_awaddr), .m_axi_awvalid(z_awvalid), .m_axi_awready(zero1),
        .m_axi_wdata(z_wdata), .m_axi_wvalid(z_wvalid), .m_axi_wready(zero1),
        .m_axi_bvalid(zero1), .m_axi_bready(z_bready),
        .m_axi_araddr(z_araddr), .m_axi_arvalid(z_arvalid), .m_axi_arready(zero1),
        .m_axi_rdata(zero32), .m_axi_rvalid(zero1), .m_axi_rready(z_rready),
        .mem_req(z_mreq), .mem_addr(z_maddr), .mem_wdata(z_mwdata), .mem_gnt(zero1),
        .start(start0), .busy(busy0), .done(done0), .err(err0), .core_rst_n(core0)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- behavioural QSPI master + memory model ----------------
    int aw_dly, w_dly, b_dly, ar_dly, r_dly, g_dly, busy_polls;
    bit stuck = 0;
    logic [31:0] flash [logic [31:0]];
    logic [63:0] mem_q [$];
    int  n_done = 0, n_polls = 0, n_data = 0, viol = 0;
    int  cyc = 0, ctrl_cyc = 0, min_gap = 1000;
    bit  hold_armed = 0, stat_clear = 0, done_prev = 0;
    int  polls_left = 0;
    bit  aw_got = 0, w_got = 0, ar_got = 0, b_fire = 0, r_fire = 0, m_wait = 0;
    int  aw_w = 0, w_w = 0, b_w = 0, ar_w = 0, r_w = 0, g_w = 0;
    logic [31:0] aw_a, w_d, ar_a, reg_addr, m_pa, m_pd;

    function automatic void apply_write(input logic [31:0] a, input logic [31:0] d);
        if (a == 32'h04) reg_addr = d;
        else if (a == 32'h00 && d == 32'h3) begin
            polls_left = busy_polls;
            stat_clear = 0;
            ctrl_cyc   = cyc;
            hold_armed = 1;
        end else viol++;
    endfunction

    function automatic logic [31:0] read_reg(input logic [31:0] a);
        logic [31:0] v = 32'h0;
        if (a == 32'h28) begin
            n_polls++;
            if (stuck || polls_left > 0) begin
                if (polls_left > 0) polls_left--;
                v = 32'h1;
            end else stat_clear = 1;
        end else if (a == 32'h08) begin
            n_data++;
            if (!stat_clear) viol++;
            stat_clear = 0;
            v = flash.exists(reg_addr) ? flash[reg_addr] : 32'hBAD0_BAD0;
        end else viol++;
        return v;
    endfunction

    always @(negedge aclk) begin
        cyc++;
        if (!aresetn) begin
            m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0;
            m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = 0; mem_gnt = 0;
            aw_got = 0; w_got = 0; ar_got = 0; b_fire = 0; r_fire = 0; m_wait = 0;
            aw_w = 0; w_w = 0; b_w = 0; ar_w = 0; r_w = 0; g_w = 0; hold_armed = 0;
            done_prev = 0;
        end else begin
            if (done) begin n_done++; if (done_prev) viol++; end
            done_prev = done;
            if (m_axi_arvalid && (m_axi_awvalid || m_axi_wvalid || m_axi_bready)) viol++;
            if ((m_axi_awvalid || m_axi_wvalid || m_axi_bready || m_axi_arvalid ||
                 m_axi_rready || mem_req) && !busy) viol++;
            if (hold_armed && m_axi_arvalid) begin
                if (cyc - ctrl_cyc < min_gap) min_gap = cyc - ctrl_cyc;
                hold_armed = 0;
            end
            // write channels
            if (b_fire) begin
                m_axi_bvalid = 0; b_fire = 0; aw_got = 0; w_got = 0;
                apply_write(aw_a, w_d);
            end else if (aw_got && w_got && !m_axi_bvalid) begin
                if (b_w >= b_dly) begin m_axi_bvalid = 1; b_w = 0; end else b_w++;
            end
            m_axi_awready = 0; m_axi_wready = 0;
            if (!aw_got && m_axi_awvalid) begin
                if (aw_w >= aw_dly) begin m_axi_awready = 1; aw_got = 1; aw_w = 0; aw_a = m_axi_awaddr; end
                else aw_w++;
            end
            if (!w_got && m_axi_wvalid) begin
                if (w_w >= w_dly) begin m_axi_wready = 1; w_got = 1; w_w = 0; w_d = m_axi_wdata; end
                else w_w++;
            end
            if (m_axi_bvalid && m_axi_bready) b_fire = 1;
            // read channels
            if (r_fire) begin
                m_axi_rvalid = 0; r_fire = 0; ar_got = 0;
            end else if (ar_got && !m_axi_rvalid) begin
                if (r_w >= r_dly) begin m_axi_rvalid = 1; r_w = 0; m_axi_rdata = read_reg(ar_a); end
                else r_w++;
            end
            m_axi_arready = 0;
            if (!ar_got && m_axi_arvalid) begin
                if (ar_w >= ar_dly) begin m_axi_arready = 1; ar_got = 1; ar_w = 0; ar_a = m_axi_araddr; end
                else ar_w++;
            end
            if (m_axi_rvalid && m_axi_rready) r_fire = 1;
            // destination memory
            if (mem_gnt) mem_gnt = 0;
            else if (mem_req) begin
                if (m_wait && (mem_addr != m_pa || mem_wdata != m_pd)) viol++;
                if (!m_wait) begin m_wait = 1; m_pa = mem_addr; m_pd = mem_wdata; end
                if (g_w >= g_dly) begin
                    mem_gnt = 1; g_w = 0; m_wait = 0;
                    mem_q.push_back({mem_addr, mem_wdata});
                end else g_w++;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctrl"}, 64'({busy, done, err, core_rst_n, m_axi_awvalid, m_axi_wvalid,
                                   m_axi_bready, m_axi_arvalid, m_axi_rready, mem_req}), 64'h0);
        check({tag, "_bus"}, 64'(m_axi_awaddr | m_axi_wdata | m_axi_araddr | mem_addr | mem_wdata), 64'h0);
    endtask

    task automatic do_reset();
        @(negedge aclk);
        aresetn = 1'b0;
        #1;
        check_reset_outputs("reset");
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
    endtask

    task automatic clear_stats();
        n_done = 0; n_polls = 0; n_data = 0; viol = 0; min_gap = 1000;
        mem_q.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge aclk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output bit ok);
        ok = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge aclk);
            if (n_done > 0) begin ok = 1; break; end
        end
        repeat (4) @(negedge aclk);
    endtask

    task automatic wait_mem(input int n, input int limit, output bit ok);
        ok = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge aclk);
            if (mem_q.size() >= n) begin ok = 1; break; end
        end
    endtask

    // reference: word i of flash lands at MEM_BASE + 4*i
    task automatic compare_copy(input string tag, input logic [63:0] exp_q [$]);
        logic [63:0] got;
        check({tag, "_nwrites"}, 64'(mem_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < mem_q.size()) ? mem_q[i] : 64'hFFFF_FFFF_FFFF_FFFF;
            check($sformatf("%s_mem%0d", tag, i), got, exp_q[i]);
        end
    endtask

    task automatic load_flash(input bit fixed, output logic [63:0] exp_q [$]);
        logic [31:0] w;
        flash.delete();
        exp_q.delete();
        for (int i = 0; i < BW; i++) begin
            w = fixed ? ((i == 0) ? 32'hDEAD_BEEF : 32'h1234_5678) : $urandom;
            flash[FB + 32'(4 * i)] = w;
            exp_q.push_back({MB + 32'(4 * i), w});
        end
    endtask

    typedef struct {
        int aw, w, b, ar, r, g, polls;
        bit fixed, mid_start;
        int exp_done;
        bit exp_core;
    } vec_t;

    vec_t tbl [8];

    initial begin
        logic [63:0] exp_q [$];
        bit ok;

        aresetn = 1'b0; start = 1'b0; start0 = 1'b0;
        aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0; g_dly = 0; busy_polls = 0;

        tbl[0] = '{0, 0, 0, 0, 0, 0, 0,  1'b1, 1'b0, 1, 1'b1};
        tbl[1] = '{0, 0, 0, 0, 0, 0, 50, 1'b0, 1'b0, 1, 1'b1};
        tbl[2] = '{3, 0, 0, 0, 0, 5, 2,  1'b0, 1'b0, 1, 1'b1};
        tbl[3] = '{1, 2, 1, 2, 1, 1, 3,  1'b0, 1'b1, 1, 1'b1};
        for (int i = 4; i < 8; i++)
            tbl[i] = '{int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), int'($urandom_range(0, 6)),
                       int'($urandom_range(0, 8)), 1'b0, 1'($urandom_range(0, 1)), 1, 1'b1};

        // zero-word boot: done two cycles after start, no bus traffic
        do_reset();
        start0 = 1'b1;
        @(negedge aclk);
        start0 = 1'b0;
        check("zw_busy_c1", 64'({busy0, done0}), 64'b10);
        @(negedge aclk);
        check("zw_done_c2", 64'({busy0, done0, core0}), 64'b011);
        @(negedge aclk);
        check("zw_done_c3", 64'({busy0, done0, core0, err0}), 64'b0010);
        check("zw_no_bus", 64'({z_awvalid, z_wvalid, z_arvalid, z_mreq}), 64'h0);

        for (int v = 0; v < 8; v++) begin
            aw_dly = tbl[v].aw; w_dly = tbl[v].w; b_dly = tbl[v].b;
            ar_dly = tbl[v].ar; r_dly = tbl[v].r; g_dly = tbl[v].g; busy_polls = tbl[v].polls;
            do_reset();
            clear_stats();
            load_flash(tbl[v].fixed, exp_q);
            pulse_start();
            if (tbl[v].mid_start) begin
                wait_mem(1, 3000, ok);
                check($sformatf("v%0d_first_word", v), 64'(ok), 64'h1);
                pulse_start();
            end
            wait_done(5000, ok);
            check($sformatf("v%0d_done_seen", v), 64'(ok), 64'h1);
            compare_copy($sformatf("v%0d", v), exp_q);
            check($sformatf("v%0d_done_pulses", v), 64'(n_done), 64'(tbl[v].exp_done));
            check($sformatf("v%0d_core_rst_n", v), 64'(core_rst_n), 64'(tbl[v].exp_core));
            check($sformatf("v%0d_busy_err", v), 64'({busy, err}), 64'h0);
            check($sformatf("v%0d_data_reads", v), 64'(n_data), 64'(BW));
            check($sformatf("v%0d_polls", v), 64'(n_polls), 64'(BW * (tbl[v].polls + 1)));
            check($sformatf("v%0d_hold_ok", v), 64'(min_gap >= 4), 64'h1);
            check($sformatf("v%0d_protocol", v), 64'(viol), 64'h0);
        end

        // reset while fetching word 1 abandons the copy; the next boot restarts at word 0
        aw_dly = 1; w_dly = 0; b_dly = 1; ar_dly = 1; r_dly = 1; g_dly = 2; busy_polls = 2;
        do_reset();
        clear_stats();
        load_flash(1'b0, exp_q);
        pulse_start();
        wait_mem(1, 3000, ok);
        check("mid_rst_word0", 64'(ok), 64'h1);
        repeat (6) @(negedge aclk);
        aresetn = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        clear_stats();
        pulse_start();
        wait_done(5000, ok);
        check("restart_done_seen", 64'(ok), 64'h1);
        compare_copy("restart", exp_q);
        check("restart_protocol", 64'(viol), 64'h0);

        aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0; g_dly = 0;
`ifdef QSPI_BOOT_TIMEOUT_EN
        // status stuck busy: copy aborts with err after 1024 polls
        stuck = 1;
        do_reset();
        clear_stats();
        load_flash(1'b0, exp_q);
        pulse_start();
        ok = 0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge aclk);
            if (err) begin ok = 1; break; end
        end
        repeat (10) @(negedge aclk);
        check("to_err_seen", 64'(ok), 64'h1);
        check("to_polls", 64'(n_polls), 64'd1024);
        check("to_outputs", 64'({err, busy, done, core_rst_n}), 64'b1000);
        check("to_done_pulses", 64'(n_done), 64'h0);
        check("to_no_writes", 64'(mem_q.size()), 64'h0);
        stuck = 0;
`else
        // polling is unbounded: more than 1024 busy polls still completes the copy
        busy_polls = 1030;
        do_reset();
        clear_stats();
        load_flash(1'b0, exp_q);
        pulse_start();
        wait_done(40000, ok);
        check("long_done_seen", 64'(ok), 64'h1);
        compare_copy("long", exp_q);
        check("long_polls", 64'(n_polls), 64'(BW * 1031));
        check("long_err", 64'({err, core_rst_n}), 64'b01);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
